// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: multiply/divide opcode encoding and the
// state encoding of the iterative mul/div sequencer.
package mips_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  typedef logic [1:0] md_state_t;

  localparam md_state_t MD_IDLE = 2'd0;
  localparam md_state_t MD_CALC = 2'd1;
  localparam md_state_t MD_FIX  = 2'd2;
  localparam md_state_t MD_DONE = 2'd3;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract
// for divide. The accumulator holds {hi_half, lo_half} for both operations.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] rem;
  logic             ge;
  logic [2*WIDTH-1:0] mult_out;
  logic [2*WIDTH-1:0] div_out;

  // Multiply: low half carries the remaining multiplier bits, product grows from the top.
  assign sum      = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, operand};
  assign mult_out = acc_in[0] ? {sum, acc_in[WIDTH-1:1]}
                              : {1'b0, acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1:1]};

  // Divide: remainder lives in the high half, dividend shifts out / quotient shifts in below.
  assign shifted = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, operand});
  assign diff    = shifted[WIDTH-1:0] - operand;
  assign rem     = ge ? diff : shifted[WIDTH-1:0];
  assign div_out = {rem, acc_in[WIDTH-2:0], ge};

  assign acc_out = is_div ? div_out : mult_out;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO; stalls the pipeline
// while an operation is in flight.
module muldiv_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             abort,
  input  logic             read_hilo,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_t          state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd_reg;
  logic               is_div_reg;
  logic               neg_res_reg;
  logic               neg_rem_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;

  md_op_t           op_e;
  logic             in_div;
  logic             in_signed;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign op_e      = md_op_t'(op);
  assign in_div    = (op_e == MD_DIV) || (op_e == MD_DIVU);
  assign in_signed = (op_e == MD_MULT) || (op_e == MD_DIV);
  assign mag_a     = (in_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign mag_b     = (in_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_reg),
    .acc_in  (acc_reg),
    .operand (opnd_reg),
    .acc_out (acc_next)
  );

  // Sign fixup applied in FIX to the unsigned magnitude result.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_fix = neg_res_reg ? -acc_reg : acc_reg;
  assign quot_fix = neg_res_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
  assign rem_fix  = neg_rem_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg   <= MD_IDLE;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      opnd_reg    <= '0;
      is_div_reg  <= 1'b0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      case (state_reg)
        MD_IDLE: begin
          if (start && !abort) begin
            if (in_div && (rt_val == '0)) begin
              hi_reg    <= rs_val;
              lo_reg    <= '1;
              state_reg <= MD_DONE;
            end else begin
              // Multiplier (mult) or dividend (div) seeds the low half.
              acc_reg     <= {{WIDTH{1'b0}}, (in_div ? mag_a : mag_b)};
              opnd_reg    <= in_div ? mag_b : mag_a;
              is_div_reg  <= in_div;
              neg_res_reg <= in_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
              neg_rem_reg <= in_signed && in_div && rs_val[WIDTH-1];
              cnt_reg     <= '0;
              state_reg   <= MD_CALC;
            end
          end
        end
        MD_CALC: begin
          if (abort) begin
            state_reg <= MD_IDLE;
          end else begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(WIDTH - 1))
              state_reg <= MD_FIX;
          end
        end
        MD_FIX: begin
          if (abort) begin
            state_reg <= MD_IDLE;
          end else begin
            if (is_div_reg) begin
              hi_reg <= rem_fix;
              lo_reg <= quot_fix;
            end else begin
              hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
              lo_reg <= prod_fix[WIDTH-1:0];
            end
            state_reg <= MD_DONE;
          end
        end
        default: state_reg <= MD_IDLE;
      endcase
    end
  end

  assign busy  = (state_reg != MD_IDLE);
  assign done  = (state_reg == MD_DONE);
  assign stall = (state_reg == MD_CALC) || (state_reg == MD_FIX) ||
                 (read_hilo && busy && (state_reg != MD_DONE));
  assign hi    = hi_reg;
  assign lo    = lo_reg;

endmodule
